// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter
//   Round-robin arbiter that merges NUM_REQ OBI requester ports onto a single
//   OBI master port. A FIFO records the requester index of every granted
//   transaction, so responses return to their issuers in issue order.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i / gnt_o       per-requester OBI request / grant
//   addr_i, we_i, be_i, wdata_i
//                       per-requester address-phase fields (packed, requester k
//                       at slice k)
//   rvalid_o, rdata_o   per-requester response valid, broadcast read data
//   m_*                 shared OBI master port
//   outstanding_o       number of in-flight transactions
//   err_o               sticky: a response arrived with nothing in flight
module obi_rr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDX_W           = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    input  logic [NUM_REQ*32-1:0]                addr_i,
    input  logic [NUM_REQ-1:0]                   we_i,
    input  logic [NUM_REQ*4-1:0]                 be_i,
    input  logic [NUM_REQ*32-1:0]                wdata_i,
    output logic [NUM_REQ-1:0]                   rvalid_o,
    output logic [31:0]                          rdata_o,
    output logic                                 m_req_o,
    input  logic                                 m_gnt_i,
    output logic [31:0]                          m_addr_o,
    output logic                                 m_we_o,
    output logic [3:0]                           m_be_o,
    output logic [31:0]                          m_wdata_o,
    input  logic                                 m_rvalid_i,
    input  logic [31:0]                          m_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
    localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0]     r_rr_ptr;
    logic                 r_lock_v;
    logic [IDX_W-1:0]     r_lock_idx;
    logic [IDX_W-1:0]     r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [IDX_W-1:0]     w_off;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_rr_sel;
    logic [IDX_W-1:0]     w_sel;
    logic [IDX_W:0]       w_sel_p1;
    logic [IDX_W-1:0]     w_next_ptr;
    logic [IDX_W-1:0]     w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // Rotate the request vector so that bit 0 is the requester at rr_ptr;
    // the lowest set bit of the rotated vector is then the offset of the winner.
    assign w_req_dbl = {req_i, req_i} >> r_rr_ptr;
    assign w_req_rot = w_req_dbl[NUM_REQ-1:0];

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (w_req_rot[k]) w_off = IDX_W'(k);
        end
    end

    assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_rr_sel = (w_sum >= NREQ_W) ? IDX_W'(w_sum - NREQ_W) : IDX_W'(w_sum);
    // A stalled request stays locked so the address phase cannot change
    // underneath the slave until it is granted.
    assign w_sel    = r_lock_v ? r_lock_idx : w_rr_sel;

    assign w_sel_p1   = {1'b0, w_sel} + 1'b1;
    assign w_next_ptr = (w_sel_p1 == NREQ_W) ? '0 : IDX_W'(w_sel_p1);

    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];

    // Fullness uses the registered count, so a same-cycle pop never unblocks.
    assign m_req_o = ((|req_i) | r_lock_v) & ~w_full;
    assign w_push  = m_req_o & m_gnt_i;
    assign w_pop   = m_rvalid_i & ~w_empty;

    always_comb begin
        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_wdata_o = '0;
        gnt_o     = '0;
        rvalid_o  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel == IDX_W'(k)) begin
                m_addr_o  = addr_i[k*32 +: 32];
                m_we_o    = we_i[k];
                m_be_o    = be_i[k*4 +: 4];
                m_wdata_o = wdata_i[k*32 +: 32];
                gnt_o[k]  = w_push;
            end
            if (w_head == IDX_W'(k)) begin
                rvalid_o[k] = w_pop;
            end
        end
    end

    assign rdata_o       = m_rdata_i;
    assign outstanding_o = r_count;
    assign err_o         = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= '0;
            r_lock_v   <= 1'b0;
            r_lock_idx <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_rr_ptr <= w_next_ptr;
                r_lock_v <= 1'b0;
                r_wptr   <= r_wptr + 1'b1;
            end else if (m_req_o) begin
                r_lock_v   <= 1'b1;
                r_lock_idx <= w_sel;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (m_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_sel;
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
module tb_obi_rr_arbiter;

    localparam int N  = 4;
    localparam int MO = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_i;
    logic [N-1:0]    gnt_o;
    logic [N*32-1:0] addr_i;
    logic [N-1:0]    we_i;
    logic [N*4-1:0]  be_i;
    logic [N*32-1:0] wdata_i;
    logic [N-1:0]    rvalid_o;
    logic [31:0]     rdata_o;
    logic            m_req_o;
    logic            m_gnt_i;
    logic [31:0]     m_addr_o;
    logic            m_we_o;
    logic [3:0]      m_be_o;
    logic [31:0]     m_wdata_o;
    logic            m_rvalid_i;
    logic [31:0]     m_rdata_i;
    logic [2:0]      outstanding_o;
    logic            err_o;

    obi_rr_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o),
        .m_we_o(m_we_o), .m_be_o(m_be_o), .m_wdata_o(m_wdata_o),
        .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // scoreboard queues: expected grant / response requester indices
    int exp_gnt_q[$];
    int exp_rv_q[$];

    // reference model: spec-level state
    int mdl_rr;
    bit mdl_lock;
    int mdl_lidx;
    int mdl_inflight[$];
    bit mdl_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mdl_sel(input logic [N-1:0] rq);
        if (mdl_lock) return mdl_lidx;
        for (int k = 0; k < N; k++) begin
            if (rq[(mdl_rr + k) % N]) return (mdl_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic mdl_clear();
        mdl_rr   = 0;
        mdl_lock = 0;
        mdl_lidx = 0;
        mdl_inflight.delete();
        mdl_err  = 0;
    endtask

    // One clock cycle: drive, predict, check address-phase outputs, advance model.
    task automatic step(input logic [N-1:0] rq, input bit g, input bit rv, input bit rs);
        int  s;
        bit  mreq;
        bit  had;
        @(negedge clk_i);
        req_i      = rq;
        m_gnt_i    = g;
        m_rvalid_i = rv;
        rst_i      = rs;
        for (int k = 0; k < N; k++) begin
            addr_i[k*32 +: 32]  = $urandom;
            wdata_i[k*32 +: 32] = $urandom;
        end
        we_i      = N'($urandom);
        be_i      = (N*4)'($urandom);
        m_rdata_i = $urandom;
        #1;
        s    = mdl_sel(rq);
        mreq = (s >= 0) && (mdl_inflight.size() < MO);
        chk("m_req", 64'(m_req_o), 64'(mreq));
        chk("outstanding", 64'(outstanding_o), 64'(mdl_inflight.size()));
        chk("err", 64'(err_o), 64'(mdl_err));
        chk("rdata", 64'(rdata_o), 64'(m_rdata_i));
        if (s >= 0) begin
            chk("m_addr", 64'(m_addr_o), 64'(addr_i[s*32 +: 32]));
            chk("m_wdata", 64'(m_wdata_o), 64'(wdata_i[s*32 +: 32]));
        end
        if (mreq && g) exp_gnt_q.push_back(s);
        had = (mdl_inflight.size() > 0);
        if (rv && had) exp_rv_q.push_back(mdl_inflight[0]);
        if (rs) begin
            mdl_clear();
        end else begin
            if (rv) begin
                if (had) void'(mdl_inflight.pop_front());
                else     mdl_err = 1;
            end
            if (mreq && g) begin
                mdl_inflight.push_back(s);
                mdl_rr   = (s + 1) % N;
                mdl_lock = 0;
            end else if (mreq) begin
                mdl_lock = 1;
                mdl_lidx = s;
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mdl_inflight.size() > 0 && guard < 20) begin
            step('0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_budget", 64'(mdl_inflight.size()), 64'd0);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents gnt/rvalid
    initial begin
        int e;
        forever begin
            @(negedge clk_i);
            #2;
            if (gnt_o !== '0) begin
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 64'(gnt_o), 64'd0);
                else begin
                    e = exp_gnt_q.pop_front();
                    chk("gnt", 64'(gnt_o), 64'd1 << e);
                end
            end
            if (rvalid_o !== '0) begin
                if (exp_rv_q.size() == 0) chk("rvalid_unexpected", 64'(rvalid_o), 64'd0);
                else begin
                    e = exp_rv_q.pop_front();
                    chk("rvalid", 64'(rvalid_o), 64'd1 << e);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; req_i = '0; m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
        addr_i = '0; wdata_i = '0; we_i = '0; be_i = '0; m_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        mdl_clear();

        // reset state and idle outputs
        step('0, 1'b0, 1'b0, 1'b0);

        // all requesting, always granted, response one cycle after each grant
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (4) step(4'b1111, 1'b1, 1'b1, 1'b0);
        drain();
        step('0, 1'b0, 1'b0, 1'b1);

        // stalled request on 2 stays locked while 0 joins
        repeat (3) step(4'b0100, 1'b0, 1'b0, 1'b0);
        step(4'b0101, 1'b0, 1'b0, 1'b0);
        step(4'b0101, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        drain();

        // fill the FIFO, then one response unblocks on the following cycle
        repeat (4) step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        drain();

        // response with nothing in flight sets a sticky error
        step('0, 1'b0, 1'b1, 1'b0);
        repeat (2) step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b0);

        // simultaneous grant and response at count 2
        repeat (2) step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        drain();

        // reset at count 3 discards in-flight work and rewinds the pointer
        repeat (3) step(4'b1111, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);
        step(4'b1010, 1'b1, 1'b0, 1'b0);
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(N'($urandom),
                 $urandom_range(0, 3) != 0,
                 (mdl_inflight.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0),
                 $urandom_range(0, 199) == 0);
        end
        drain();
        step('0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        #3;
        chk("gnt_scoreboard_empty", 64'(exp_gnt_q.size()), 64'd0);
        chk("rvalid_scoreboard_empty", 64'(exp_rv_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obi_rr_arbiter.md
OBI_RR_ARBITER -- requirements
Module: obi_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of OBI requester ports (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, the depth of the in-flight transaction FIFO (power of 2, >=2).
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_REQ), the width of the requester index.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, reset; reset is synchronous and active-high.
REQ-006 SHALL have port req_i, input, NUM_REQ bits, the per-requester OBI req.
REQ-007 SHALL have port gnt_o, output, NUM_REQ bits, the per-requester OBI gnt.
REQ-008 SHALL have port addr_i, input, NUM_REQ*32 bits, the per-requester address; requester k occupies bits [32k+31:32k].
REQ-009 SHALL have port we_i, input, NUM_REQ bits, the per-requester write enable.
REQ-010 SHALL have port be_i, input, NUM_REQ*4 bits, the per-requester byte enables.
REQ-011 SHALL have port wdata_i, input, NUM_REQ*32 bits, the per-requester write data.
REQ-012 SHALL have port rvalid_o, output, NUM_REQ bits, the per-requester response valid.
REQ-013 SHALL have port rdata_o, output, 32 bits, read data broadcast to all requesters.
REQ-014 SHALL have ports m_req_o (out, 1), m_gnt_i (in, 1), m_addr_o (out, 32), m_we_o (out, 1), m_be_o (out, 4), m_wdata_o (out, 32), m_rvalid_i (in, 1) and m_rdata_i (in, 32), forming the shared OBI master port.
REQ-015 SHALL have port outstanding_o, output, $clog2(MAX_OUTSTANDING+1) bits, the number of in-flight transactions.
REQ-016 SHALL have port err_o, output, 1 bit, a sticky flag set when a response arrives with no transaction in flight.

Function
REQ-017 SHALL keep a round-robin pointer rr_ptr (IDX_W bits); the selected index sel is the first k with req_i[k]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
REQ-018 SHALL keep a lock register (lock_v, lock_idx); while lock_v=1, sel=lock_idx regardless of req_i.
REQ-019 SHALL drive m_req_o = (any req_i, or lock_v) AND NOT fifo_full; all m_* request fields SHALL combinationally mux from requester sel.
REQ-020 SHALL drive gnt_o[sel] = m_gnt_i AND m_req_o; all other gnt_o bits SHALL be 0; the grant path is combinational (zero added latency).
REQ-021 SHALL, on handshake (m_req_o AND m_gnt_i), push sel into the FIFO, set rr_ptr to (sel+1) mod NUM_REQ, and clear lock_v.
REQ-022 SHALL, when m_req_o=1 and m_gnt_i=0, set lock_v=1 and lock_idx=sel next cycle, so the OBI address phase stays stable until granted.
REQ-023 SHALL leave rr_ptr unchanged when no handshake occurs.
REQ-024 SHALL, on m_rvalid_i with the FIFO non-empty, assert rvalid_o[head] for that same cycle only and pop the head; rdata_o = m_rdata_i combinationally at all times.
REQ-025 SHALL, on m_rvalid_i with the FIFO empty, keep rvalid_o all 0, leave the FIFO unchanged, and set err_o=1 until reset.
REQ-026 SHALL treat fifo_full as count==MAX_OUTSTANDING; a pop in the same cycle SHALL NOT unblock m_req_o in that cycle.
REQ-027 SHALL, on simultaneous push and pop, leave the count unchanged and advance both read and write pointers, with wrap-around modulo MAX_OUTSTANDING.
REQ-028 SHALL drive outstanding_o equal to the FIFO count (registered).
REQ-029 SHALL deliver responses in issue order only; no reordering is permitted.
REQ-030 SHALL expect requesters to hold req_i and their fields stable until gnt_o; a lock_idx requester dropping req_i SHALL still present its m_* fields, and this is a protocol violation that is not checked.

Reset
REQ-031 SHALL, while rst_i=1 at a clock edge, clear rr_ptr to 0, lock_v to 0, FIFO pointers and count to 0, and err_o to 0.
REQ-032 SHALL, during and after reset, drive gnt_o, rvalid_o and m_req_o to 0 only when req_i is all 0; outstanding_o SHALL read 0 in the cycle after reset.
REQ-033 SHALL, on reset mid-operation, discard in-flight entries; later m_rvalid_i SHALL set err_o.

Verification
REQ-034 SHALL be verified with: req_i=4'b1111 and m_gnt_i=1 always, with responses 1 cycle after each grant -> grants in the order 0,1,2,3,0; rvalid_o matches the same order.
REQ-035 SHALL be verified with: req_i[2] high and m_gnt_i=0 for 3 cycles, then req_i[0] also raised -> m_addr_o stays at requester 2 and the first gnt goes to 2.
REQ-036 SHALL be verified with: 4 grants and no rvalid -> m_req_o=0 and outstanding_o=4; one rvalid -> m_req_o returns to 1 on the next cycle.
REQ-037 SHALL be verified with: m_rvalid_i pulse with outstanding_o=0 -> rvalid_o=0 and err_o=1 held until rst_i.
REQ-038 SHALL be verified with: a grant and an rvalid in the same cycle at count=2 -> count stays 2 and the correct rvalid_o index is asserted.
REQ-039 SHALL be verified with: rst_i asserted at count=3 -> outstanding_o=0 and rr_ptr=0 (the next grant is to the lowest requesting index).
